// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decodes the immediate field of a RISC-V instruction and sign- or
//   zero-extends it to XLEN bits. The decoded entry {imm_ext, tag, illegal}
//   then passes through a 2-entry skid buffer: a main output register and a
//   skid register. in_ready comes straight from a flop, so the upstream
//   handshake has no combinational path from out_ready or in_valid.
//
// Parameters
//   XLEN   output immediate width (32 or 64)
//   TAG_W  width of the sideband tag
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of both buffered entries
//   in_valid     upstream offers an entry
//   in_ready     block can accept an entry this cycle (registered)
//   imm_src      format: 0 I, 1 S, 2 B, 3 J, 4 U, 5 Z (CSR uimm), 6-7 illegal
//   instr        instruction bits [31:7]
//   in_tag       sideband tag, passed through unmodified
//   out_valid    output entry valid
//   out_ready    downstream accepts the output entry
//   imm_ext      extended immediate
//   out_tag      tag of the output entry
//   out_illegal  output entry came from an illegal imm_src
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_src,
  input  logic [24:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Only the two RISC-V register widths make sense for this decoder.
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;
  localparam logic [2:0] SRC_Z = 3'd5;

  // instr holds instruction bits [31:7], so instruction bit k sits at
  // instr[k-7]. The sign bit (instruction bit 31) is therefore instr[24].
  logic            sign;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  assign sign = instr[24];

  // Decode at the input so every buffer entry already holds the final
  // immediate; the output side is then a plain register with no logic.
  // Illegal selects produce a zero immediate with the illegal flag raised.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    unique case (imm_src)
      SRC_I: dec_imm = {{(XLEN-12){sign}}, instr[24:13]};
      SRC_S: dec_imm = {{(XLEN-12){sign}}, instr[24:18], instr[4:0]};
      SRC_B: dec_imm = {{(XLEN-12){sign}}, instr[0], instr[23:18],
                        instr[4:1], 1'b0};
      SRC_J: dec_imm = {{(XLEN-20){sign}}, instr[12:5], instr[13],
                        instr[23:14], 1'b0};
      SRC_U: dec_imm = {{(XLEN-32){sign}}, instr[24:5], 12'b0};
      SRC_Z: dec_imm = {{(XLEN-5){1'b0}}, instr[12:8]};
      default: begin
        dec_imm = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_ill;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;
  logic             in_ready_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid && out_ready;

  // Skid buffer control and storage. The main register only changes when it
  // is empty or drains, which keeps the outputs stable during a stall. When
  // the main register is stuck and a new entry arrives it parks in the skid
  // register and in_ready drops the following cycle; the skid entry moves
  // forward on the next drain and in_ready comes back. Because in_ready is
  // low whenever the skid register is full, no input can arrive in that
  // state. Flush wins over everything, including a same-cycle input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_ill   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_ill   <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (skid_valid) begin
      if (out_xfer) begin
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        main_ill   <= skid_ill;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end
    end else if (main_valid) begin
      if (in_xfer && !out_ready) begin
        skid_imm   <= dec_imm;
        skid_tag   <= in_tag;
        skid_ill   <= dec_ill;
        skid_valid <= 1'b1;
        in_ready_q <= 1'b0;
      end else if (in_xfer) begin
        main_imm <= dec_imm;
        main_tag <= in_tag;
        main_ill <= dec_ill;
      end else if (out_ready) begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      main_imm   <= dec_imm;
      main_tag   <= in_tag;
      main_ill   <= dec_ill;
      main_valid <= 1'b1;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign imm_ext     = main_imm;
  assign out_tag     = main_tag;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical stimulus. A
//   queue of expected entries doubles as the occupancy model: its size at the
//   start of a cycle gives the expected out_valid and in_ready, and its head
//   is the entry that must be on the outputs.
module tb_imm_extend_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2:0]       imm_src = '0;
  logic [24:0]      instr = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready32, out_valid32, ill32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             in_ready64, out_valid64, ill64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .imm_src(imm_src), .instr(instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm32),
    .out_tag(tag32), .out_illegal(ill32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .imm_src(imm_src), .instr(instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm64),
    .out_tag(tag64), .out_illegal(ill64)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t q[$];
  int   occStart = 0;
  int   passed = 0;
  int   total = 0;
  bit   monitorOn = 1'b0;

  task automatic checkVal(input string name, input logic [63:0] act,
                          input logic [63:0] req);
    total++;
    if (act !== req)
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    else
      passed++;
  endtask

  // Sign-extend the low 'bits' bits of v to 64 bits with plain arithmetic.
  function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
    longint signed t;
    t = longint'({32'b0, v});
    t = t <<< (64 - bits);
    t = t >>> (64 - bits);
    return t;
  endfunction

  function automatic logic [24:0] hi25(input logic [31:0] w);
    return w[31:7];
  endfunction

  // Reference decode: rebuild the full instruction word and assemble each
  // immediate straight from the format table.
  function automatic exp_t refModel(input logic [2:0] src,
                                    input logic [24:0] ins,
                                    input logic [TAG_W-1:0] tag);
    logic [31:0] ir;
    exp_t e;
    ir = {ins, 7'b0};
    e.tag = tag;
    e.ill = 1'b0;
    case (src)
      3'd0: e.imm = sx({20'b0, ir[31:20]}, 12);
      3'd1: e.imm = sx({20'b0, ir[31:25], ir[11:7]}, 12);
      3'd2: e.imm = sx({19'b0, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}, 13);
      3'd3: e.imm = sx({11'b0, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}, 21);
      3'd4: e.imm = sx({ir[31:12], 12'b0}, 32);
      3'd5: e.imm = {59'b0, ir[19:15]};
      default: begin
        e.imm = '0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Compare both instances against the model for the current cycle, then
  // retire the head entry if the downstream takes it at the coming edge.
  task automatic checkOutput();
    exp_t e;
    occStart = q.size();
    checkVal("in_ready32", 64'(in_ready32), 64'(occStart < 2));
    checkVal("in_ready64", 64'(in_ready64), 64'(occStart < 2));
    checkVal("out_valid32", 64'(out_valid32), 64'(occStart > 0));
    checkVal("out_valid64", 64'(out_valid64), 64'(occStart > 0));
    if (occStart > 0) begin
      e = q[0];
      checkVal("imm_ext32", 64'(imm32), 64'(e.imm[31:0]));
      checkVal("imm_ext64", imm64, e.imm);
      checkVal("out_tag32", 64'(tag32), 64'(e.tag));
      checkVal("out_tag64", 64'(tag64), 64'(e.tag));
      checkVal("out_illegal32", 64'(ill32), 64'(e.ill));
      checkVal("out_illegal64", 64'(ill64), 64'(e.ill));
      if (out_ready) e = q.pop_front();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && monitorOn) checkOutput();
    end
  end

  // Resolve the handshake for the cycle just driven: flush clears the model,
  // otherwise an offered entry is accepted when the model has room.
  task automatic finishCycle(input exp_t pend, output bit acc);
    @(negedge clk);
    #2;
    acc = 1'b0;
    if (flush) begin
      q.delete();
      acc = 1'b1;
    end else if (in_valid && occStart < 2) begin
      q.push_back(pend);
      acc = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] src,
                               input logic [24:0] ins,
                               input logic [TAG_W-1:0] tag, input bit fl,
                               input bit ordy, input bit useLit,
                               input logic [63:0] lit, output bit acc);
    exp_t pend;
    @(posedge clk);
    #1;
    in_valid  = v;
    imm_src   = src;
    instr     = ins;
    in_tag    = tag;
    flush     = fl;
    out_ready = ordy;
    pend = refModel(src, ins, tag);
    if (useLit) pend.imm = lit;
    finishCycle(pend, acc);
  endtask

  task automatic checkResetState(input string where);
    checkVal({where, "_out_valid"}, 64'({out_valid32, out_valid64}), 64'(0));
    checkVal({where, "_in_ready"}, 64'({in_ready32, in_ready64}), 64'(3));
    checkVal({where, "_imm32"}, 64'(imm32), 64'(0));
    checkVal({where, "_imm64"}, imm64, 64'(0));
    checkVal({where, "_tag"}, 64'({tag32, tag64}), 64'(0));
    checkVal({where, "_illegal"}, 64'({ill32, ill64}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit acc;
    bit pat [4];
    exp_t pend;
    int t;
    int cyc;
    logic [31:0] r;
    logic [31:0] r2;
    logic [TAG_W-1:0] tagCnt;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state, then an I-type entry offered while reset releases so the
    // very first edge after deassertion accepts it.
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    in_valid  = 1'b1;
    imm_src   = 3'd0;
    instr     = hi25(32'hFFF00093);
    in_tag    = 5'd3;
    out_ready = 1'b1;
    pend = refModel(3'd0, hi25(32'hFFF00093), 5'd3);
    pend.imm = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    rst_n = 1'b1;
    monitorOn = 1'b1;
    finishCycle(pend, acc);

    // Directed formats with spec-derived expected immediates.
    applyStimulus(1, 3'd2, hi25(32'hFE000EE3), 5'd4, 0, 1, 1,
                  64'hFFFF_FFFF_FFFF_FFFC, acc);
    applyStimulus(1, 3'd3, hi25(32'h0080006F), 5'd5, 0, 1, 1,
                  64'h8, acc);
    applyStimulus(1, 3'd4, hi25(32'h800000B7), 5'd6, 0, 1, 1,
                  64'hFFFF_FFFF_8000_0000, acc);
    applyStimulus(1, 3'd5, 25'h01F00, 5'd7, 0, 1, 1, 64'h1F, acc);
    applyStimulus(1, 3'd7, 25'h1FFFFFF, 5'd8, 0, 1, 1, 64'h0, acc);
    repeat (3) applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);

    // Tags 0-9 with out_ready cycling 1,0,0,1; each tag is re-offered until
    // the model shows room for it.
    t = 0;
    cyc = 0;
    while (t < 10 && cyc < 80) begin
      r = $urandom();
      applyStimulus(1, r[27:25], r[24:0], 5'(t), 0, pat[cyc % 4], 0, 64'h0,
                    acc);
      if (acc) t++;
      cyc++;
    end
    if (t < 10) begin
      total++;
      $display("[TB] FAIL stream_budget: actual=%0d required=10", t);
    end
    repeat (4) applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);

    // Flush with both entries full and an input offered.
    applyStimulus(1, 3'd0, 25'h12345, 5'd20, 0, 0, 0, 64'h0, acc);
    applyStimulus(1, 3'd1, 25'h0ABCD, 5'd21, 0, 0, 0, 64'h0, acc);
    applyStimulus(1, 3'd0, 25'h1F0F0, 5'd22, 1, 0, 0, 64'h0, acc);
    applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);

    // Flush with one entry held and an input that would have been accepted.
    applyStimulus(1, 3'd0, 25'h00777, 5'd23, 0, 0, 0, 64'h0, acc);
    applyStimulus(1, 3'd2, 25'h1C001, 5'd24, 1, 0, 0, 64'h0, acc);
    applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);
    applyStimulus(1, 3'd3, 25'h0F00F, 5'd25, 0, 1, 0, 64'h0, acc);

    // Reset pulse with two entries buffered.
    applyStimulus(1, 3'd4, 25'h13579, 5'd26, 0, 0, 0, 64'h0, acc);
    applyStimulus(1, 3'd1, 25'h02468, 5'd27, 0, 0, 0, 64'h0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    q.delete();
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);

    // Randomized traffic with stalls and occasional flushes.
    tagCnt = '0;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      r2 = $urandom();
      applyStimulus(r[1:0] != 2'b00, r[12:10], r2[24:0], tagCnt,
                    r[7:3] == 5'd0, r[8] | r[9], 0, 64'h0, acc);
      if (acc && in_valid) tagCnt++;
    end
    repeat (5) applyStimulus(0, 3'd0, 25'h0, 5'd0, 0, 1, 0, 64'h0, acc);

    monitorOn = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
